upb_10g_output: RTL and testbench

Store-and-forward transmit stage between the switch fabric and the 10G MAC transmit interface, the counterpart of the 10G input stage. Buffers each complete packet from the switch-side AXI4-Stream before releasing it, so the MAC never sees a mid-frame gap. Discards oversize packets and packets flagged bad by the upstream stage, and counts them.

---
 rtl/upb_10g_pkg.sv | 34 +++
 rtl/upb_10g_output_ram.sv | 32 +++
 rtl/upb_10g_output.sv | 198 +++++++++++++++++++
 tb/tb_upb_10g_output.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upb_10g_pkg.sv
// Shared types and constants for the 10G store-and-forward output stage.
// Buffer word layout, FSM state encodings and default sizing.
package upb_10g_pkg;

  localparam int DATA_WIDTH        = 64;
  localparam int KEEP_WIDTH        = DATA_WIDTH / 8;
  localparam int MAX_PKT_WORDS_DEF = 1125;
  localparam int FIFO_DEPTH_DEF    = 4096;

  typedef struct packed {
    logic                  last;
    logic [KEEP_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] data;
  } buf_word_t;

  localparam int BUF_WIDTH = $bits(buf_word_t);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_SEND     = 2'd2
  } rd_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/upb_10g_output_ram.sv
// Simple dual-port packet buffer: one write port, one synchronous read port
// with a single cycle of read latency.
module upb_10g_output_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 73,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk156,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset: the top gates everything read from here with its own valid.
  always_ff @(posedge clk156) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/upb_10g_output.sv
// Store-and-forward transmit stage: whole packets are buffered and committed
// before the MAC side sees them; bad and oversize packets are rewound away.
module upb_10g_output
  import upb_10g_pkg::*;
#(
  parameter int MAX_PKT_WORDS = upb_10g_pkg::MAX_PKT_WORDS_DEF,
  parameter int FIFO_DEPTH    = upb_10g_pkg::FIFO_DEPTH_DEF
) (
  input  logic                  clk156,
  input  logic                  axi_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] mac_m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] mac_m_axis_tkeep,
  output logic                  mac_m_axis_tuser,
  output logic                  mac_m_axis_tvalid,
  input  logic                  mac_m_axis_tready,
  output logic                  mac_m_axis_tlast,
  output logic [31:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_PKT_WORDS);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  wr_state_t       wr_state_q, wr_state_d;
  rd_state_t       rd_state_q, rd_state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]     drop_count_q, drop_count_d;
  logic            ready_en_q, ready_en_d;

  logic            wr_acc;
  logic            commit;
  logic            ram_we;
  logic            ram_re;
  logic            rd_acc;
  logic            send_done;
  logic            m_valid;
  logic            pending_after;
  buf_word_t       wr_word;
  buf_word_t       rd_word;
  logic [BUF_WIDTH-1:0] ram_rd_data;

  assign wr_word = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
  assign rd_word = buf_word_t'(ram_rd_data);

  // ready_en keeps tready low until the first edge after reset release.
  assign ready_en_d    = 1'b1;
  assign s_axis_tready = ready_en_q &
                         ((wr_state_q == WR_DROP) || ((wr_ptr_q - rd_ptr_q) != DEPTH_P));
  assign wr_acc        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    word_cnt_d   = word_cnt_q;
    drop_count_d = drop_count_q;
    ram_we       = 1'b0;
    commit       = 1'b0;
    case (wr_state_q)
      WR_IDLE, WR_PKT: begin
        if (wr_acc) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ONE_P;
          word_cnt_d = word_cnt_q + CW'(1);
          wr_state_d = WR_PKT;
          if (s_axis_tlast) begin
            word_cnt_d = '0;
            wr_state_d = WR_IDLE;
            if (!s_axis_tuser && (word_cnt_q < MAX_W)) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + ONE_P;
            end else begin
              wr_ptr_d     = commit_ptr_q;
              drop_count_d = sat_inc32(drop_count_q);
            end
          end else if (word_cnt_q == MAX_W - CW'(1)) begin
            // Oversize: discard what was written and swallow the rest.
            wr_ptr_d   = commit_ptr_q;
            word_cnt_d = '0;
            wr_state_d = WR_DROP;
          end
        end
      end
      WR_DROP: begin
        if (wr_acc && s_axis_tlast) begin
          drop_count_d = sat_inc32(drop_count_q);
          wr_state_d   = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign m_valid = (rd_state_q == RD_SEND);
  assign rd_acc  = m_valid & mac_m_axis_tready;
  // Packets still queued once the current one completes (incl. a same-cycle commit).
  assign pending_after = (pkt_count_q > ONE_P) || commit;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    ram_re     = 1'b0;
    send_done  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (pkt_count_q != '0) begin
          rd_state_d = RD_PREFETCH;
        end
      end
      RD_PREFETCH: begin
        ram_re     = 1'b1;
        rd_ptr_d   = rd_ptr_q + ONE_P;
        rd_state_d = RD_SEND;
      end
      RD_SEND: begin
        if (rd_acc) begin
          if (rd_word.last) begin
            send_done  = 1'b1;
            rd_state_d = pending_after ? RD_PREFETCH : RD_IDLE;
          end else begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + ONE_P;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (commit && !send_done) begin
      pkt_count_d = pkt_count_q + ONE_P;
    end else if (!commit && send_done) begin
      pkt_count_d = pkt_count_q - ONE_P;
    end
  end

  always_ff @(posedge clk156 or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      word_cnt_q   <= '0;
      drop_count_q <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      word_cnt_q   <= word_cnt_d;
      drop_count_q <= drop_count_d;
      ready_en_q   <= ready_en_d;
    end
  end

  upb_10g_output_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUF_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk156  (clk156),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_word),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  // The RAM output register is not reset, so everything is masked by valid.
  assign mac_m_axis_tvalid = m_valid;
  assign mac_m_axis_tdata  = m_valid ? rd_word.data : '0;
  assign mac_m_axis_tkeep  = m_valid ? rd_word.keep : '0;
  assign mac_m_axis_tlast  = m_valid & rd_word.last;
  assign mac_m_axis_tuser  = 1'b0;
  assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_upb_10g_output.sv
// Self-checking bench for upb_10g_output: table of single-packet cases,
// back-pressure / reset sequences, and a randomized run against a packet model.
module tb_upb_10g_output;

  localparam int MAXW = 1125;
  localparam int TMO  = 20000;

  typedef logic [72:0] w73_t;

  typedef struct {
    int         len;
    logic [7:0] lkeep;
    logic       tuser;
    bit         exp_drop;
    int         exp_words;
  } vec_t;

  logic        clk156 = 1'b0;
  logic        axi_resetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] mac_m_axis_tdata;
  logic [7:0]  mac_m_axis_tkeep;
  logic        mac_m_axis_tuser;
  logic        mac_m_axis_tvalid;
  logic        mac_m_axis_tready = 1'b0;
  logic        mac_m_axis_tlast;
  logic [31:0] drop_count;

  upb_10g_output dut (
    .clk156            (clk156),
    .axi_resetn        (axi_resetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .mac_m_axis_tdata  (mac_m_axis_tdata),
    .mac_m_axis_tkeep  (mac_m_axis_tkeep),
    .mac_m_axis_tuser  (mac_m_axis_tuser),
    .mac_m_axis_tvalid (mac_m_axis_tvalid),
    .mac_m_axis_tready (mac_m_axis_tready),
    .mac_m_axis_tlast  (mac_m_axis_tlast),
    .drop_count        (drop_count)
  );

  always #5 clk156 = ~clk156;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Output monitor: collects accepted words, checks protocol properties.
  w73_t got_q[$];
  w73_t exp_q[$];
  int   gaps_q[$];
  int   gap_err = 0, stab_err = 0, tuser_err = 0;
  int   gap_run = 0, rise_cyc = 0;
  bit   in_pkt = 0, after_last = 0, hold_v = 0, prev_v = 0;
  w73_t hold_w, mon_w;
  bit   rand_rdy = 0;

  always @(negedge clk156) begin
    if (!axi_resetn) begin
      in_pkt = 0; after_last = 0; hold_v = 0; prev_v = 0;
    end else begin
      mon_w = {mac_m_axis_tlast, mac_m_axis_tkeep, mac_m_axis_tdata};
      if (mac_m_axis_tuser) tuser_err++;
      if (mac_m_axis_tvalid && !prev_v) rise_cyc = cyc;
      if (in_pkt && !mac_m_axis_tvalid) gap_err++;
      if (hold_v && (!mac_m_axis_tvalid || mon_w != hold_w)) stab_err++;
      if (after_last) begin
        if (mac_m_axis_tvalid) begin gaps_q.push_back(gap_run); after_last = 0; end
        else gap_run++;
      end
      hold_v = 0;
      if (mac_m_axis_tvalid && mac_m_axis_tready) begin
        got_q.push_back(mon_w);
        in_pkt = !mac_m_axis_tlast;
        if (mac_m_axis_tlast) begin after_last = 1; gap_run = 0; end
      end else if (mac_m_axis_tvalid) begin
        hold_v = 1; hold_w = mon_w;
      end
      prev_v = mac_m_axis_tvalid;
    end
  end

  always @(posedge clk156) begin
    if (rand_rdy) begin
      #1 mac_m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  int acc_words = 0, stalls = 0, last_acc_cyc = 0, exp_drops = 0;

  task automatic finish_now(input string why);
    $display("FAIL %s: got timeout expected progress", why);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "stopping: %s", why);
  endtask

  task automatic wait_accept();
    int n = 0;
    bit ok;
    do begin
      @(negedge clk156); ok = s_axis_tready;
      @(posedge clk156); #1;
      if (!ok) begin stalls++; n++; end
    end while (!ok && n < TMO);
    if (!ok) finish_now("accept_timeout");
    acc_words++;
    last_acc_cyc = cyc;
  endtask

  // Called at posedge+1; 'keep' says whether the model expects it forwarded.
  task automatic send_pkt(input int len, input logic [7:0] lkeep, input logic tuser,
                          input int id, input bit gaps, input bit keep);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      d = {16'(id), 16'(i), 32'($urandom)};
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk156); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = (i == len - 1);
      s_axis_tkeep  = (i == len - 1) ? lkeep : 8'hFF;
      s_axis_tuser  = (i == len - 1) ? tuser : 1'b0;
      wait_accept();
      if (keep) exp_q.push_back({s_axis_tlast, s_axis_tkeep, d});
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic check_stream(input string name, input int exp_words);
    int n = 0;
    int mism = 0;
    while (got_q.size() < exp_q.size() && n < TMO) begin @(posedge clk156); n++; end
    repeat (10) @(posedge clk156);
    #1;
    check({name, "_words"}, got_q.size(), exp_words);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({name, "_data"}, mism, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic release_reset(input string name);
    @(posedge clk156); #1;
    axi_resetn = 1'b1;
    @(negedge clk156);
    check({name, "_tready_before_edge"}, s_axis_tready, 0);
    @(negedge clk156);
    check({name, "_tready_after_edge"}, s_axis_tready, 1);
    @(posedge clk156); #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5,    8'h0F, 1'b0, 1'b0, 5};
    vecs[1] = '{1125, 8'hFF, 1'b0, 1'b0, 1125};
    vecs[2] = '{1400, 8'h3F, 1'b0, 1'b1, 0};
    vecs[3] = '{5,    8'h0F, 1'b0, 1'b0, 5};
    vecs[4] = '{5,    8'hFF, 1'b1, 1'b1, 0};
    vecs[5] = '{1,    8'h01, 1'b0, 1'b0, 1};
    vecs[6] = '{1126, 8'hFF, 1'b0, 1'b1, 0};
    vecs[7] = '{1124, 8'h80, 1'b0, 1'b0, 1124};
    vecs[8] = '{2,    8'hFF, 1'b1, 1'b1, 0};
    vecs[9] = '{3,    8'h07, 1'b0, 1'b0, 3};

    repeat (3) @(negedge clk156);
    check("rst_tready", s_axis_tready, 0);
    check("rst_outs", {mac_m_axis_tvalid, mac_m_axis_tlast, |mac_m_axis_tdata,
                       |mac_m_axis_tkeep, |drop_count}, 0);
    release_reset("init");

    // Table-driven single packets, MAC always ready.
    mac_m_axis_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stalls = 0;
      send_pkt(vecs[k].len, vecs[k].lkeep, vecs[k].tuser, k, 0, !vecs[k].exp_drop);
      if (vecs[k].exp_drop) exp_drops++;
      check_stream($sformatf("vec%0d", k), vecs[k].exp_words);
      check($sformatf("vec%0d_drops", k), drop_count, exp_drops);
      check($sformatf("vec%0d_stalls", k), stalls, 0);
      if (!vecs[k].exp_drop)
        check($sformatf("vec%0d_latency", k), rise_cyc - last_acc_cyc, 2);
    end

    // Back-pressure: four max packets so the buffer genuinely fills.
    mac_m_axis_tready = 1'b0;
    acc_words = 0;
    gaps_q.delete();
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(MAXW, 8'hFF, 1'b0, 100 + p, 0, 1);
      end
      begin
        int n;
        int ones;
        n = 0;
        while (s_axis_tready && n < TMO) begin @(negedge clk156); n++; end
        // 4096 words in the RAM plus the first word already in the read register.
        check("bp_full_at", acc_words, 4097);
        repeat (20) @(negedge clk156);
        check("bp_full_hold", {s_axis_tready, mac_m_axis_tvalid}, 2'b01);
        check("bp_full_words", acc_words, 4097);
        @(posedge clk156); #1;
        mac_m_axis_tready = 1'b1;
        n = 0;
        while (gaps_q.size() < 4 && n < TMO) begin @(posedge clk156); n++; end
        ones = 0;
        for (int i = 1; i < gaps_q.size(); i++) if (gaps_q[i] == 1) ones++;
        check("bp_b2b_gaps", (gaps_q.size() == 4) ? ones : -1, 3);
      end
    join
    check_stream("bp", 4 * MAXW);
    check("bp_drops", drop_count, exp_drops);

    // Randomized packets, tvalid gaps and random MAC back-pressure.
    rand_rdy = 1;
    for (int p = 0; p < 30; p++) begin
      int   len;
      logic tu;
      bit   drop;
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(1120, 1300) : $urandom_range(1, 24);
      tu   = ($urandom_range(0, 7) == 0);
      drop = tu || (len > MAXW);
      if (drop) exp_drops++;
      send_pkt(len, 8'hFF >> $urandom_range(0, 7), tu, 300 + p, 1, !drop);
    end
    rand_rdy = 0;
    @(posedge clk156); #2;
    mac_m_axis_tready = 1'b1;
    check_stream("rand", exp_q.size());
    check("rand_drops", drop_count, exp_drops);

    // Reset in the middle of transmitting a packet.
    mac_m_axis_tready = 1'b0;
    send_pkt(40, 8'h3F, 1'b0, 500, 0, 1);
    repeat (5) @(posedge clk156);
    #1 mac_m_axis_tready = 1'b1;
    repeat (10) @(posedge clk156);
    #1 axi_resetn = 1'b0;
    #1;
    check("midrst_outs", {mac_m_axis_tvalid, mac_m_axis_tlast, |mac_m_axis_tdata,
                          |mac_m_axis_tkeep, |drop_count, s_axis_tready}, 0);
    got_q.delete();
    exp_q.delete();
    exp_drops = 0;
    repeat (3) @(posedge clk156);
    release_reset("midrst");
    send_pkt(5, 8'h0F, 1'b0, 600, 0, 1);
    check_stream("post_rst", 5);
    check("post_rst_latency", rise_cyc - last_acc_cyc, 2);
    check("post_rst_drops", drop_count, exp_drops);

    check("valid_gaps_in_pkt", gap_err, 0);
    check("data_stable_while_held", stab_err, 0);
    check("mac_tuser_zero", tuser_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    finish_now("watchdog");
  end

endmodule
